// File: rtl/fnn_layer_seq.sv
// Sequencer for one fully connected layer: buffers an input vector, broadcasts it to all neurons,
// collects their outputs and streams them out. Define FNN_LAYER_ARGMAX_EN for a running argmax.
module fnn_layer_seq #(
  parameter int unsigned numInput    = 784,
  parameter int unsigned numNeuron   = 30,
  parameter int unsigned dataWidth   = 16,
  parameter int unsigned inAddrWidth = (numInput > 1) ? $clog2(numInput) : 1,
  parameter int unsigned outIdxWidth = (numNeuron > 1) ? $clog2(numNeuron) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [dataWidth-1:0]           s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [dataWidth-1:0]           nrn_in,
  output logic                           nrn_in_valid,
  input  logic [numNeuron*dataWidth-1:0] nrn_out,
  input  logic [numNeuron-1:0]           nrn_outvalid,
  output logic [dataWidth-1:0]           m_data,
  output logic                           m_valid,
  output logic                           m_last,
  input  logic                           m_ready,
  output logic                           busy,
  output logic                           done,
  output logic [outIdxWidth-1:0]         arg_idx,
  output logic                           arg_valid
);

  typedef enum logic [2:0] {StIdle, StLoad, StFeed, StWait, StDrain} state_t;

  localparam logic [inAddrWidth-1:0] LastAddr = inAddrWidth'(numInput - 1);
  localparam logic [outIdxWidth-1:0] LastIdx  = outIdxWidth'(numNeuron - 1);

  state_t                 r_state, w_state_d;
  logic [inAddrWidth-1:0] r_wr_cnt, r_rd_addr;
  logic [dataWidth-1:0]   r_buf [numInput];
  logic [dataWidth-1:0]   r_nrn_in;
  logic                   r_nrn_in_valid;
  logic [dataWidth-1:0]   r_res [numNeuron];
  logic [numNeuron-1:0]   r_cap;
  logic [outIdxWidth-1:0] r_rd_idx;
  logic                   r_done;
  logic                   w_load_hs, w_m_hs, w_m_last_hs;

  assign s_ready      = (r_state == StLoad);
  assign m_valid      = (r_state == StDrain);
  assign busy         = (r_state != StIdle);
  assign w_load_hs    = s_ready & s_valid;
  assign w_m_hs       = m_valid & m_ready;
  assign w_m_last_hs  = w_m_hs && (r_rd_idx == LastIdx);
  assign m_data       = r_res[r_rd_idx];
  assign m_last       = m_valid && (r_rd_idx == LastIdx);
  assign nrn_in       = r_nrn_in;
  assign nrn_in_valid = r_nrn_in_valid;
  assign done         = r_done;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = StLoad;
      StLoad:  if (w_load_hs && (r_wr_cnt == LastAddr)) w_state_d = StFeed;
      StFeed:  if (r_rd_addr == LastAddr) w_state_d = StWait;
      // Bits captured this cycle count towards completion.
      StWait:  if (&(r_cap | nrn_outvalid)) w_state_d = StDrain;
      StDrain: if (w_m_last_hs) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Input buffer is plain RAM: contents survive reset.
  always_ff @(posedge clk) begin
    if (w_load_hs) r_buf[r_wr_cnt] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      r_wr_cnt       <= '0;
      r_rd_addr      <= '0;
      r_nrn_in       <= '0;
      r_nrn_in_valid <= 1'b0;
      r_cap          <= '0;
      r_rd_idx       <= '0;
      r_done         <= 1'b0;
      for (int i = 0; i < int'(numNeuron); i++) r_res[i] <= '0;
    end else begin
      r_state        <= w_state_d;
      r_done         <= 1'b0;
      r_nrn_in_valid <= 1'b0;
      if (w_load_hs) r_wr_cnt <= (r_wr_cnt == LastAddr) ? '0 : r_wr_cnt + 1'b1;
      if (r_state == StFeed) begin
        r_nrn_in       <= r_buf[r_rd_addr];
        r_nrn_in_valid <= 1'b1;
        r_rd_addr      <= (r_rd_addr == LastAddr) ? '0 : r_rd_addr + 1'b1;
      end
      if (r_state == StWait) begin
        for (int i = 0; i < int'(numNeuron); i++) begin
          if (nrn_outvalid[i]) begin
            r_res[i] <= nrn_out[i*dataWidth +: dataWidth];
            r_cap[i] <= 1'b1;
          end
        end
      end
      if (w_m_hs) begin
        if (w_m_last_hs) begin
          r_rd_idx <= '0;
          r_cap    <= '0;
          r_done   <= 1'b1;
        end else begin
          r_rd_idx <= r_rd_idx + 1'b1;
        end
      end
    end
  end

`ifdef FNN_LAYER_ARGMAX_EN
  logic signed [dataWidth-1:0] r_max;
  logic [outIdxWidth-1:0]      r_max_idx, r_arg_idx;
  logic                        r_arg_valid;
  logic                        w_take;

  // Strict compare so ties keep the earlier index.
  assign w_take    = (r_rd_idx == '0) || ($signed(m_data) > r_max);
  assign arg_idx   = r_arg_idx;
  assign arg_valid = r_arg_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max       <= '0;
      r_max_idx   <= '0;
      r_arg_idx   <= '0;
      r_arg_valid <= 1'b0;
    end else begin
      r_arg_valid <= 1'b0;
      if ((r_state == StIdle) && start) r_arg_idx <= '0;
      if (w_m_hs && w_take) begin
        r_max     <= $signed(m_data);
        r_max_idx <= r_rd_idx;
      end
      if (w_m_last_hs) begin
        r_arg_idx   <= w_take ? r_rd_idx : r_max_idx;
        r_arg_valid <= 1'b1;
      end
    end
  end
`else
  assign arg_idx   = '0;
  assign arg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fnn_layer_seq.sv
// Self-checking bench for fnn_layer_seq (numInput=4, numNeuron=3): table vectors, random passes,
// reset during feed and ignored start/outvalid sequences.
module tb_fnn_layer_seq;
  localparam int NI = 4;
  localparam int NN = 3;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst, start, s_valid, m_ready;
  logic [DW-1:0]     s_data, nrn_in, m_data;
  logic              s_ready, nrn_in_valid, m_valid, m_last, busy, done, arg_valid;
  logic [NN*DW-1:0]  nrn_out;
  logic [NN-1:0]     nrn_outvalid;
  logic [1:0]        arg_idx;

  int checks = 0;
  int errors = 0;
  int pat [5] = '{1, 0, 0, 1, 1};

  typedef struct packed {
    logic [NI-1:0][DW-1:0] din;
    logic [NN-1:0][DW-1:0] res;
    logic [1:0]            arrive;
    logic [1:0]            rmode;
    logic                  stray;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  fnn_layer_seq #(
    .numInput (NI),
    .numNeuron(NN),
    .dataWidth(DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .nrn_in      (nrn_in),
    .nrn_in_valid(nrn_in_valid),
    .nrn_out     (nrn_out),
    .nrn_outvalid(nrn_outvalid),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .busy        (busy),
    .done        (done),
    .arg_idx     (arg_idx),
    .arg_valid   (arg_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // Signed maximum, earliest index wins ties.
  function automatic int exp_argmax(input logic [NN-1:0][DW-1:0] r);
    int best = 0;
    for (int i = 1; i < NN; i++) if ($signed(r[i]) > $signed(r[best])) best = i;
    return best;
  endfunction

  task automatic run_pass(input logic [NI-1:0][DW-1:0] din, input logic [NN-1:0][DW-1:0] res,
                          input int arrive, input int rmode, input bit stray, input bit gaps);
    int h, cyc, ng;
    bit rdy;
    if (stray) begin
      nrn_out = '1;
      nrn_outvalid = '1;
      @(negedge clk);
      nrn_outvalid = '0;
      chk("idle_stray_busy", 32'(busy), 32'd0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
`ifdef FNN_LAYER_ARGMAX_EN
    chk("arg_idx_cleared", 32'(arg_idx), 32'd0);
`endif
    for (int k = 0; k < NI; k++) begin
      ng = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < ng; g++) begin
        s_valid = 1'b0;
        chk("load_ready_gap", 32'(s_ready), 32'd1);
        @(negedge clk);
      end
      chk("load_ready", 32'(s_ready), 32'd1);
      s_data = din[k];
      s_valid = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_data = '0;
    chk("feed_ready_low", 32'(s_ready), 32'd0);
    chk("feed_pre_valid", 32'(nrn_in_valid), 32'd0);
    for (int k = 0; k < NI; k++) begin
      @(negedge clk);
      chk("feed_valid", 32'(nrn_in_valid), 32'd1);
      chk("feed_data", 32'(nrn_in), 32'(din[k]));
    end
    @(negedge clk);
    chk("feed_end", 32'(nrn_in_valid), 32'd0);
    // Neuron pipeline latency, with an ignored start pulse.
    for (int w = 0; w < 4; w++) begin
      if (stray && w == 0) start = 1'b1;
      chk("wait_no_drain", 32'(m_valid), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < NN; i++) nrn_out[i*DW +: DW] = res[i];
    if (arrive == 0) begin
      nrn_outvalid = '1;
      @(negedge clk);
      nrn_outvalid = '0;
    end else begin
      nrn_out[DW +: DW] = ~res[1];
      nrn_outvalid = 3'b010;
      @(negedge clk);
      nrn_outvalid = '0;
      chk("stag_no_drain_a", 32'(m_valid), 32'd0);
      @(negedge clk);
      nrn_out[DW +: DW] = res[1];
      nrn_outvalid = 3'b001;
      @(negedge clk);
      nrn_outvalid = 3'b010;
      chk("stag_no_drain_b", 32'(m_valid), 32'd0);
      @(negedge clk);
      nrn_outvalid = '0;
      chk("stag_no_drain_c", 32'(m_valid), 32'd0);
      @(negedge clk);
      nrn_outvalid = 3'b100;
      @(negedge clk);
      nrn_outvalid = '0;
    end
    chk("drain_start", 32'(m_valid), 32'd1);
    // Outvalid during DRAIN must not disturb the results.
    nrn_out = ~nrn_out;
    nrn_outvalid = '1;
    h = 0;
    cyc = 0;
    while (h < NN && cyc < 40) begin
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc < 5) ? (pat[cyc] != 0) : 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      chk("m_valid", 32'(m_valid), 32'd1);
      chk("m_data", 32'(m_data), 32'(res[h]));
      chk("m_last", 32'(m_last), 32'(h == NN - 1));
      chk("done_low", 32'(done), 32'd0);
      m_ready = rdy;
      @(negedge clk);
      if (rdy) h++;
      cyc++;
    end
    m_ready = 1'b0;
    nrn_outvalid = '0;
    chk("drain_count", 32'(h), 32'(NN));
    chk("post_valid", 32'(m_valid), 32'd0);
    chk("done", 32'(done), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
`ifdef FNN_LAYER_ARGMAX_EN
    chk("arg_valid", 32'(arg_valid), 32'd1);
    chk("arg_idx", 32'(arg_idx), 32'(exp_argmax(res)));
`else
    chk("arg_valid_off", 32'(arg_valid), 32'd0);
    chk("arg_idx_off", 32'(arg_idx), 32'd0);
`endif
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("arg_valid_pulse", 32'(arg_valid), 32'd0);
`ifdef FNN_LAYER_ARGMAX_EN
    chk("arg_idx_hold", 32'(arg_idx), 32'(exp_argmax(res)));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NI-1:0][DW-1:0] rdin;
    logic [NN-1:0][DW-1:0] rres;
    rst = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    nrn_out = '0;
    nrn_outvalid = '0;

    vecs[0] = '{din: {16'd4, 16'd3, 16'd2, 16'd1}, res: {16'h0200, 16'hFF00, 16'h0100},
                arrive: 2'd0, rmode: 2'd0, stray: 1'b0};
    vecs[1] = '{din: {16'd6, 16'd7, 16'd8, 16'd9}, res: {16'h0030, 16'h0020, 16'h0010},
                arrive: 2'd1, rmode: 2'd0, stray: 1'b1};
    vecs[2] = '{din: {16'hD, 16'hC, 16'hB, 16'hA}, res: {16'h0001, 16'h7FFF, 16'h7FFF},
                arrive: 2'd0, rmode: 2'd1, stray: 1'b0};
    vecs[3] = '{din: {16'h1234, 16'h8000, 16'hFFFF, 16'h0}, res: {16'hFFFF, 16'h8001, 16'h8000},
                arrive: 2'd1, rmode: 2'd2, stray: 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_nrn_valid", 32'(nrn_in_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_arg_valid", 32'(arg_valid), 32'd0);
    chk("rst_arg_idx", 32'(arg_idx), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++)
      run_pass(vecs[v].din, vecs[v].res, int'(vecs[v].arrive), int'(vecs[v].rmode),
               vecs[v].stray, 1'b0);

    // Reset while two words of the broadcast have gone out.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < NI; k++) begin
      s_data = DW'(k + 20);
      s_valid = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_feed_valid", 32'(nrn_in_valid), 32'd1);
    chk("mid_feed_data", 32'(nrn_in), 32'd21);
    #1 rst = 1'b1;
    #1;
    chk("arst_nrn_valid", 32'(nrn_in_valid), 32'd0);
    chk("arst_nrn_in", 32'(nrn_in), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_pass({16'd8, 16'd7, 16'd6, 16'd5}, {16'h0005, 16'h0104, 16'hFFF0}, 0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NI; k++) rdin[k] = DW'($urandom);
      for (int i = 0; i < NN; i++) rres[i] = DW'($urandom);
      run_pass(rdin, rres, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fnn_layer_seq.md
Name: fnn_layer_seq

Overview:
- Sequencer for one fully connected layer of Neuron instances.
- Accepts an input vector into a local buffer, then broadcasts it to all neurons of the layer as a myinput/myinputValid burst.
- Collects every neuron's out/outvalid, then streams the results to the next layer over a valid/ready interface.
- Sits between two layers, or between the input DMA and layer 1.

Parameters:
- numInput, 784, words per input vector (equals the neurons' numWeight)
- numNeuron, 30, neurons in the controlled layer
- dataWidth, 16, width of input and output words
- inAddrWidth, $clog2(numInput), input buffer address width
- outIdxWidth, $clog2(numNeuron), result index width (minimum 1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a layer pass; sampled only in IDLE
- s_data  in  dataWidth  input vector word
- s_valid  in  1  s_data valid
- s_ready  out  1  high only in LOAD
- nrn_in  out  dataWidth  broadcast to every neuron's myinput
- nrn_in_valid  out  1  broadcast to every neuron's myinputValid
- nrn_out  in  numNeuron*dataWidth  neuron i output at [i*dataWidth +: dataWidth]
- nrn_outvalid  in  numNeuron  neuron i outvalid
- m_data  out  dataWidth  result word
- m_valid  out  1  m_data valid
- m_last  out  1  final result word (index numNeuron-1)
- m_ready  in  1  downstream accept
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last m handshake
- arg_idx  out  outIdxWidth  index of the maximum output (see Optional Feature)
- arg_valid  out  1  argmax valid pulse, coincident with done

Behaviour:
- Reset (async, any state): state=IDLE; all counters, capture flags and outputs 0. Buffer RAM contents are not cleared. Neurons are reset by the same rst.
- States: IDLE -> LOAD -> FEED -> WAIT -> DRAIN -> IDLE.
- IDLE:
  - start=1 moves to LOAD next cycle.
  - start in any other state is ignored.
- LOAD:
  - s_ready=1. Each s_valid&s_ready writes buffer[wr_cnt] and increments wr_cnt.
  - The handshake at wr_cnt==numInput-1 moves to FEED; s_ready drops the following cycle.
- FEED:
  - Buffer read is registered.
  - nrn_in_valid is high for exactly numInput consecutive cycles, starting the cycle after entering FEED, carrying buffer[0..numInput-1] in order. No gaps and no back-pressure.
  - After the last word: nrn_in_valid=0, move to WAIT.
- WAIT:
  - On nrn_outvalid[i]=1, capture nrn_out slice i into res[i] and set cap[i].
  - Bits arriving in different cycles are allowed; simultaneous bits are all captured.
  - A repeated outvalid for an already-captured neuron overwrites res[i].
  - nrn_outvalid outside WAIT is ignored.
  - When all cap bits are set (including ones set this cycle), move to DRAIN the next cycle.
- DRAIN:
  - m_valid=1, m_data=res[rd_idx], m_last=(rd_idx==numNeuron-1).
  - m_data and m_last hold stable while m_valid&!m_ready.
  - Each handshake increments rd_idx.
  - The last handshake: m_valid=0 next cycle, done=1 for one cycle, state=IDLE, cap cleared.
  - Back-to-back results are allowed (one per cycle with m_ready held high).
- Minimum pass latency, from start to the first m_valid: 1 + numInput (LOAD at full rate) + 1 + numInput + neuron pipeline latency + 1 cycles.

Optional Feature:
- Macro: FNN_LAYER_ARGMAX_EN.
- Defined:
  - During DRAIN, track a running signed maximum over each handshaken m_data. Ties keep the lower index.
  - With done, drive arg_valid=1 for one cycle and arg_idx=the winning index.
  - arg_idx holds its value until the next start is accepted, then clears to 0.
- Undefined: arg_idx and arg_valid are tied to 0; no comparator logic is generated.

Test Plan (numInput=4, numNeuron=3, dataWidth=16, simple neuron model with latency 5):
- Reset, then start; send s_data 1,2,3,4 at full rate -> s_ready high for 4 cycles, then nrn_in 1,2,3,4 with nrn_in_valid high exactly 4 consecutive cycles.
- Model returns 0x0100, 0xFF00, 0x0200 in the same cycle; m_ready=1 -> m_data 0x0100, 0xFF00, 0x0200 on consecutive cycles, m_last on the third, done the cycle after. With ARGMAX_EN: arg_idx=2, arg_valid=1.
- nrn_outvalid bits arrive on three different cycles -> DRAIN starts only one cycle after the third bit.
- m_ready toggles 1,0,0,1,1 -> m_data stable during the stalls; exactly 3 handshakes; m_last only on index 2.
- Assert rst mid-FEED after 2 words -> outputs immediately 0, state IDLE; a new start and load of 5,6,7,8 feeds correctly.
- start pulsed during WAIT, plus stray nrn_outvalid during IDLE -> both ignored; no state change and no captures.
